// File: rtl/quad_counter_gen.sv
// Quadrature encoder position counter: 2-FF synchroniser, x1/x2/x4 decode, wrap/saturate, preload, flags.
// Define ENC_FILTER_EN to add a FILTER_LEN-cycle glitch filter after the synchroniser.
module quad_counter_gen #(
    parameter int N          = 7,
    parameter int MIN_COUNT  = 0,
    parameter int MAX_COUNT  = 99,
    parameter int FILTER_LEN = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         canalA,
    input  logic         canalB,
    input  logic         clr,
    input  logic [1:0]   mode,
    input  logic         wrap_en,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count,
    output logic         dir,
    output logic         step,
    output logic         ovf,
    output logic         unf,
    output logic         err
);
    localparam logic [N-1:0]      MIN_V = N'(MIN_COUNT);
    localparam logic [N-1:0]      MAX_V = N'(MAX_COUNT);
    localparam logic signed [N:0] MIN_S = (N+1)'(MIN_COUNT);
    localparam logic signed [N:0] MAX_S = (N+1)'(MAX_COUNT);

    logic [1:0]        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]        prev_q, prev_d, hold_q, hold_d;
    logic [1:0]        cur;
    logic [N-1:0]      count_q, count_d;
    logic              dir_q, dir_d, step_q, step_d;
    logic              ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;
    logic              up, dn, ill, counted, dec_en, step_req;
    logic signed [N:0] lv_s;

`ifdef ENC_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [1:0]    filt_q, filt_d;
    logic [FW-1:0] fcnt_q [2];
    logic [FW-1:0] fcnt_d [2];

    // A channel level is accepted after FILTER_LEN consecutive samples that differ from the current one.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            fcnt_d[i] = fcnt_q[i];
            if (sync2_q[i] == filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
                filt_d[i] = sync2_q[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q    <= '0;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign cur = filt_q;
`else
    assign cur = sync2_q;
`endif

    // Transition classification on {prev, cur}; forward order is 00 -> 10 -> 11 -> 01 -> 00.
    always_comb begin
        up  = 1'b0;
        dn  = 1'b0;
        ill = 1'b0;
        case ({prev_q, cur})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: up  = 1'b1;
            4'b1000, 4'b1110, 4'b0111, 4'b0001: dn  = 1'b1;
            4'b0011, 4'b1100, 4'b1001, 4'b0110: ill = 1'b1;
            default: ;
        endcase
        case (mode)
            2'd0:    counted = ~prev_q[1] & cur[1];
            2'd1:    counted = prev_q[1] ^ cur[1];
            default: counted = 1'b1;
        endcase
        dec_en   = (hold_q == 2'd0);
        step_req = dec_en & (up | dn) & counted;
    end

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        sync1_d = {canalA, canalB};
        sync2_d = sync1_q;
        prev_d  = cur;
        hold_d  = (hold_q == 2'd0) ? hold_q : hold_q - 2'd1;
        lv_s    = $signed({1'b0, load_val});
        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        err_d   = dec_en & ill;
        if (clr) begin
            count_d = MIN_V;
        end else if (load) begin
            if (lv_s < MIN_S)      count_d = MIN_V;
            else if (lv_s > MAX_S) count_d = MAX_V;
            else                   count_d = load_val;
        end else if (step_req) begin
            step_d = 1'b1;
            dir_d  = up;
            if (up) begin
                if (count_q == MAX_V) begin
                    ovf_d   = 1'b1;
                    count_d = wrap_en ? MIN_V : count_q;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == MIN_V) begin
                    unf_d   = 1'b1;
                    count_d = wrap_en ? MAX_V : count_q;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the pre-edge values together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            prev_q  <= 2'b00;
            hold_q  <= 2'd3;
            count_q <= MIN_V;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign step  = step_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign err   = err_q;
endmodule

// File: tb/tb_quad_counter_gen.sv
// Self-checking bench for quad_counter_gen: vector table, hand-written corner sequences, random vs. model.
module tb_quad_counter_gen;
    localparam int N    = 7;
    localparam int MINC = 0;
    localparam int MAXC = 99;
`ifdef ENC_FILTER_EN
    localparam int LAT  = 3 + 16;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = 3;
    localparam bit FILT = 1'b0;
`endif
    localparam int HOLD = 7;

    logic         clk, rst_n, canalA, canalB, clr, wrap_en, load;
    logic [1:0]   mode;
    logic [N-1:0] load_val, count;
    logic         dir, step, ovf, unf, err;

    quad_counter_gen #(.N(N), .MIN_COUNT(MINC), .MAX_COUNT(MAXC), .FILTER_LEN(16)) dut (
        .clk(clk), .rst_n(rst_n), .canalA(canalA), .canalB(canalB), .clr(clr),
        .mode(mode), .wrap_en(wrap_en), .load(load), .load_val(load_val),
        .count(count), .dir(dir), .step(step), .ovf(ovf), .unf(unf), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_step   = 0;
    int n_err    = 0;

    always @(posedge clk) begin
        #1;
        if (step) n_step++;
        if (err)  n_err++;
    end

    // Reference model state: position, direction, last pin pair seen.
    int         m_count;
    logic       m_dir;
    logic [1:0] m_prev;
    logic       e_step, e_ovf, e_unf, e_err;
    logic [N-1:0] p_count;
    logic       p_dir, p_step, p_ovf, p_unf, p_err;

    typedef struct {
        logic [1:0] ab;
        logic [1:0] mode;
        int         exp_count;
        logic       exp_step;
        logic       exp_err;
        logic       exp_dir;
    } vec_t;
    vec_t vecs [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int seq_pos(input logic [1:0] ab);
        logic [1:0] fwd [4];
        fwd = '{2'b00, 2'b10, 2'b11, 2'b01};
        for (int i = 0; i < 4; i++)
            if (fwd[i] == ab) return i;
        return 0;
    endfunction

    function automatic logic [1:0] next_fwd(input logic [1:0] ab, input int k);
        logic [1:0] fwd [4];
        fwd = '{2'b00, 2'b10, 2'b11, 2'b01};
        return fwd[(seq_pos(ab) + k) % 4];
    endfunction

    task automatic model_trans(input logic [1:0] nab, input logic [1:0] md, input logic wr);
        int d;
        bit cnt_it;
        e_step = 1'b0; e_ovf = 1'b0; e_unf = 1'b0; e_err = 1'b0;
        d = (seq_pos(nab) - seq_pos(m_prev) + 4) % 4;
        if (d == 2) begin
            e_err = 1'b1;
        end else if (d != 0) begin
            if (md == 2'd0)      cnt_it = !m_prev[1] && nab[1];
            else if (md == 2'd1) cnt_it = m_prev[1] != nab[1];
            else                 cnt_it = 1'b1;
            if (cnt_it) begin
                e_step = 1'b1;
                m_dir  = (d == 1);
                if (d == 1) begin
                    if (m_count == MAXC) begin e_ovf = 1'b1; if (wr) m_count = MINC; end
                    else m_count = m_count + 1;
                end else begin
                    if (m_count == MINC) begin e_unf = 1'b1; if (wr) m_count = MAXC; end
                    else m_count = m_count - 1;
                end
            end
        end
        m_prev = nab;
    endtask

    task automatic do_trans(input logic [1:0] nab);
        {canalA, canalB} = nab;
        tick(LAT);
        p_count = count; p_dir = dir; p_step = step;
        p_ovf = ovf; p_unf = unf; p_err = err;
        tick(HOLD);
    endtask

    task automatic apply(input logic [1:0] nab);
        model_trans(nab, mode, wrap_en);
        do_trans(nab);
        check("model count", 32'(p_count), 32'(m_count));
        check("model step",  32'(p_step),  32'(e_step));
        check("model ovf",   32'(p_ovf),   32'(e_ovf));
        check("model unf",   32'(p_unf),   32'(e_unf));
        check("model err",   32'(p_err),   32'(e_err));
        check("model dir",   32'(p_dir),   32'(m_dir));
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = N'(v);
        tick(1);
        load = 1'b0;
        m_count = (v > MAXC) ? MAXC : ((v < MINC) ? MINC : v);
        check("load clamp", 32'(count), 32'(m_count));
        tick(1);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        m_count = MINC;
        check("clear", 32'(count), 32'(MINC));
        tick(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int s0, base;
        logic [1:0] nab;
        vecs[0]  = '{2'b10, 2'd2, 1, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{2'b11, 2'd2, 2, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{2'b01, 2'd2, 3, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{2'b00, 2'd2, 4, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{2'b10, 2'd0, 5, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{2'b11, 2'd0, 5, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{2'b01, 2'd0, 5, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{2'b00, 2'd0, 5, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{2'b01, 2'd0, 5, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{2'b11, 2'd0, 4, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{2'b10, 2'd0, 4, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{2'b00, 2'd0, 4, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{2'b10, 2'd1, 5, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{2'b11, 2'd1, 5, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{2'b01, 2'd1, 6, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{2'b00, 2'd1, 6, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{2'b01, 2'd1, 6, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{2'b11, 2'd1, 5, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{2'b10, 2'd1, 5, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{2'b00, 2'd1, 4, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{2'b11, 2'd2, 4, 1'b0, 1'b1, 1'b0};
        vecs[21] = '{2'b00, 2'd2, 4, 1'b0, 1'b1, 1'b0};
        vecs[22] = '{2'b01, 2'd2, 3, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; canalA = 1'b0; canalB = 1'b0; clr = 1'b0; load = 1'b0;
        load_val = '0; mode = 2'd2; wrap_en = 1'b0;
        m_count = MINC; m_dir = 1'b0; m_prev = 2'b00;
        tick(4);
        check("reset count", 32'(count), 32'(MINC));
        check("reset dir",   32'(dir),  0);
        check("reset pulses", 32'({step, ovf, unf, err}), 0);

        // Pins move while in reset: the hold-off window must swallow the resulting transition.
        if (!FILT) begin
            {canalA, canalB} = 2'b10;
            tick(1);
            rst_n = 1'b1;
            tick(8);
            check("holdoff count", 32'(count), 32'(MINC));
            check("holdoff steps", 32'(n_step), 0);
            check("holdoff errs",  32'(n_err), 0);
            m_prev = 2'b10;
            mode = 2'd0;
            apply(2'b00);
            mode = 2'd2;
        end else begin
            rst_n = 1'b1;
            tick(8);
        end

        // Four forward x4 cycles.
        s0 = n_step;
        for (int i = 0; i < 16; i++) apply(next_fwd(m_prev, 1));
        check("x4 fwd count", 32'(count), 16);
        check("x4 fwd steps", 32'(n_step - s0), 16);
        check("x4 fwd dir",   32'(dir), 1);

        do_clr();
        for (int i = 0; i < 23; i++) begin
            mode = vecs[i].mode;
            wrap_en = 1'b0;
            model_trans(vecs[i].ab, mode, wrap_en);
            do_trans(vecs[i].ab);
            check("vec count", 32'(p_count), 32'(vecs[i].exp_count));
            check("vec step",  32'(p_step),  32'(vecs[i].exp_step));
            check("vec err",   32'(p_err),   32'(vecs[i].exp_err));
            check("vec dir",   32'(p_dir),   32'(vecs[i].exp_dir));
        end

        // Bounds: saturate, wrap up, wrap down.
        mode = 2'd2; wrap_en = 1'b0;
        do_load(99);
        apply(next_fwd(m_prev, 1));
        check("sat count", 32'(p_count), 99);
        check("sat ovf",   32'(p_ovf), 1);
        wrap_en = 1'b1;
        do_load(99);
        apply(next_fwd(m_prev, 1));
        check("wrap up count", 32'(p_count), 0);
        check("wrap up ovf",   32'(p_ovf), 1);
        apply(next_fwd(m_prev, 3));
        check("wrap dn count", 32'(p_count), 99);
        check("wrap dn unf",   32'(p_unf), 1);
        wrap_en = 1'b0;

        // Illegal jump: err exactly LAT-1 edges after first sampling, nothing else moves.
        base = m_count;
        s0 = n_step;
        nab = m_prev ^ 2'b11;
        {canalA, canalB} = nab;
        tick(LAT - 1);
        check("err early", 32'(err), 0);
        tick(1);
        check("err pulse", 32'(err), 1);
        check("err count", 32'(count), 32'(base));
        tick(1);
        check("err one cycle", 32'(err), 0);
        check("err no step", 32'(n_step - s0), 0);
        m_prev = nab;
        tick(HOLD);

        // Clear and load collide with a decoded step: step is discarded.
        do_load(50);
        s0 = n_step;
        nab = next_fwd(m_prev, 1);
        {canalA, canalB} = nab;
        tick(LAT - 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr+step count", 32'(count), 32'(MINC));
        check("clr+step step",  32'(step), 0);
        check("clr+step ovf",   32'(ovf), 0);
        m_prev = nab; m_count = MINC;
        tick(HOLD);
        nab = next_fwd(m_prev, 1);
        {canalA, canalB} = nab;
        tick(LAT - 1);
        load = 1'b1; load_val = N'(120);
        tick(1);
        load = 1'b0;
        check("load+step count", 32'(count), 99);
        check("load+step step",  32'(step), 0);
        check("load+step ovf",   32'(ovf), 0);
        check("collide steps",   32'(n_step - s0), 0);
        m_prev = nab; m_count = MAXC;
        tick(HOLD);

`ifdef ENC_FILTER_EN
        mode = 2'd2; wrap_en = 1'b0;
        base = m_count;
        s0 = n_step;
        {canalA, canalB} = m_prev ^ 2'b10;
        tick(10);
        {canalA, canalB} = m_prev;
        tick(40);
        check("glitch count", 32'(count), 32'(base));
        check("glitch steps", 32'(n_step - s0), 0);
        nab = m_prev ^ 2'b10;
        model_trans(nab, mode, wrap_en);
        {canalA, canalB} = nab;
        tick(LAT - 1);
        check("filter early", 32'(step), 0);
        tick(1);
        check("filter step",  32'(step), 1);
        check("filter count", 32'(count), 32'(m_count));
        tick(HOLD);
`endif

        // Random traffic against the model, including occasional clear/preload between transitions.
        for (int i = 0; i < 250; i++) begin
            int r;
            mode    = 2'($urandom_range(0, 3));
            wrap_en = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r == 0) do_clr();
            else if (r == 1) do_load($urandom_range(0, 127));
            apply(2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
